// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: single-port 32-bit word memory behind an address decoder.
// Writes complete in one cycle and the FSM stays in IDLE. Reads take two
// cycles: the index is latched, the array is read into a register, and the
// word is presented for one cycle.
// DEPTH must equal 2**ADDR_W.
// Optional feature macro: DMEM_BYTE_WRITE_EN adds a per-byte write mask port.
//
// state | meaning
// IDLE  | ready for a new access; writes and rejections complete here
// RD    | array read into the output register
// RESP  | dataValid asserted with the read word on dataOut
module data_memory_ctrl #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        CS,
  input  logic        iWE,
  input  logic [31:0] iAddress,
  input  logic [31:0] dataIn,
`ifdef DMEM_BYTE_WRITE_EN
  input  logic [3:0]  byteEn,
`endif
  output logic        ready,
  output logic [31:0] dataOut,
  output logic        dataValid,
  output logic        wrAck,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [31:0]         r_mem [DEPTH];
  logic [31:0]         r_rd_data;
  logic [ADDR_W-1:0]   r_idx;
  logic                r_wr_ack;
  logic                r_err;

  logic                w_idle;
  logic                w_accept;
  logic                w_addr_ok;
  logic                w_wr;
  logic                w_rd;
  logic                w_rej;
  logic [ADDR_W-1:0]   w_idx;
  logic [3:0]          w_be;

  assign w_idle    = (r_state == S_IDLE);
  assign w_accept  = req && w_idle;
  assign w_addr_ok = CS && (iAddress[31:ADDR_W] == '0);
  assign w_wr      = w_accept && w_addr_ok && iWE;
  assign w_rd      = w_accept && w_addr_ok && !iWE;
  assign w_rej     = w_accept && !w_addr_ok;
  assign w_idx     = iAddress[ADDR_W-1:0];

`ifdef DMEM_BYTE_WRITE_EN
  assign w_be = byteEn;
`else
  assign w_be = 4'hF;
`endif

  assign ready = w_idle;
  assign wrAck = r_wr_ack;
  assign err   = r_err;

  // State register and one-cycle completion pulses; reset aborts any read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_wr_ack <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_wr_ack <= w_wr;
      r_err    <= w_rej;
      if (w_rd) begin
        r_idx <= w_idx;
      end
    end
  end

  // Memory array and read register; deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= dataIn[8*b +: 8];
        end
      end
    end
    if (r_state == S_RD) begin
      r_rd_data <= r_mem[r_idx];
    end
  end

  // Next-state decode and read-response outputs; dataOut is zero outside RESP.
  always_comb begin
    w_next    = r_state;
    dataValid = 1'b0;
    dataOut   = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (w_rd) begin
          w_next = S_RD;
        end
      end
      S_RD: begin
        w_next = S_RESP;
      end
      S_RESP: begin
        dataValid = 1'b1;
        dataOut   = r_rd_data;
        w_next    = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Testbench for data_memory_ctrl (default build, no byte enables).
// Reference model: a plain word array updated only by accepted, in-range writes.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        CS = 1'b0;
  logic        iWE = 1'b0;
  logic [31:0] iAddress = 32'h0;
  logic [31:0] dataIn = 32'h0;
  logic        ready;
  logic [31:0] dataOut;
  logic        dataValid;
  logic        wrAck;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [1024];
  int          wr_q [$];

  data_memory_ctrl #(.DEPTH(1024), .ADDR_W(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .CS        (CS),
    .iWE       (iWE),
    .iAddress  (iAddress),
    .dataIn    (dataIn),
    .ready     (ready),
    .dataOut   (dataOut),
    .dataValid (dataValid),
    .wrAck     (wrAck),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write attempt; occupies exactly one cycle so consecutive calls are back-to-back.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic cs, input string tag);
    logic valid;
    valid = cs && (addr[31:10] == 22'h0);
    req = 1'b1; CS = cs; iWE = 1'b1; iAddress = addr; dataIn = data;
    tick();
    req = 1'b0;
    if (valid) begin
      model[addr[9:0]] = data;
      wr_q.push_back(int'(addr[9:0]));
    end
    chk1({tag, "_wrack"}, wrAck, valid);
    chk1({tag, "_err"}, err, !valid);
    chk1({tag, "_dvalid"}, dataValid, 1'b0);
    chk({tag, "_dout"}, dataOut, 32'h0);
    chk1({tag, "_ready"}, ready, 1'b1);
  endtask

  // One read attempt; valid reads take three cycles back to IDLE, rejections one.
  task automatic do_read(input logic [31:0] addr, input logic cs, input string tag);
    logic valid;
    valid = cs && (addr[31:10] == 22'h0);
    req = 1'b1; CS = cs; iWE = 1'b0; iAddress = addr; dataIn = $urandom;
    tick();
    req = 1'b0;
    if (!valid) begin
      chk1({tag, "_rej_err"}, err, 1'b1);
      chk1({tag, "_rej_dvalid"}, dataValid, 1'b0);
      chk1({tag, "_rej_ready"}, ready, 1'b1);
      chk({tag, "_rej_dout"}, dataOut, 32'h0);
    end else begin
      chk1({tag, "_busy"}, ready, 1'b0);
      chk1({tag, "_early_dvalid"}, dataValid, 1'b0);
      chk({tag, "_early_dout"}, dataOut, 32'h0);
      tick();
      chk1({tag, "_dvalid"}, dataValid, 1'b1);
      chk({tag, "_data"}, dataOut, model[addr[9:0]]);
      chk1({tag, "_wrack_quiet"}, wrAck, 1'b0);
      tick();
      chk1({tag, "_dvalid_end"}, dataValid, 1'b0);
      chk({tag, "_dout_end"}, dataOut, 32'h0);
      chk1({tag, "_ready_end"}, ready, 1'b1);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          op;
    int          k;

    // Reset values while rst_n is held low.
    #1;
    chk1("rst_ready", ready, 1'b1);
    chk1("rst_dvalid", dataValid, 1'b0);
    chk1("rst_wrack", wrAck, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk("rst_dout", dataOut, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Write then read, first access on the first edge after reset release.
    do_write(32'h00F, 32'hDEADBEEF, 1'b1, "wr_0F");
    tick();
    chk1("wrack_single", wrAck, 1'b0);
    do_read(32'h00F, 1'b1, "rd_0F");

    // Boundary indices, then read both back.
    do_write(32'h000, 32'h11111111, 1'b1, "wr_000");
    do_write(32'h3FF, 32'h22222222, 1'b1, "wr_3FF");
    do_read(32'h000, 1'b1, "rd_000");
    do_read(32'h3FF, 1'b1, "rd_3FF");

    // Rejections: chip select low, then out-of-window index aliasing to 0.
    do_write(32'h00F, 32'h55555555, 1'b0, "rej_cs");
    tick();
    chk1("rej_cs_err_single", err, 1'b0);
    do_write(32'h400, 32'h66666666, 1'b1, "rej_hi");
    tick();
    chk1("rej_hi_err_single", err, 1'b0);
    do_read(32'h00F, 1'b1, "rd_after_rej_cs");
    do_read(32'h000, 1'b1, "rd_after_rej_hi");

    // Back-to-back writes followed immediately by reads of the same index.
    for (int i = 0; i < 4; i++) begin
      do_write(32'h100 + i, $urandom, 1'b1, "b2b_wr");
    end
    do_read(32'h103, 1'b1, "b2b_rd_last");
    do_write(32'h200, 32'hCAFEF00D, 1'b1, "raw_wr");
    do_read(32'h200, 1'b1, "raw_rd");

    // Write attempt while busy in RD is ignored.
    req = 1'b1; CS = 1'b1; iWE = 1'b0; iAddress = 32'h00F;
    tick();
    chk1("busy_ready", ready, 1'b0);
    iWE = 1'b1; dataIn = 32'h0BADBAD0;
    tick();
    req = 1'b0;
    chk1("busy_dvalid", dataValid, 1'b1);
    chk("busy_data", dataOut, 32'hDEADBEEF);
    chk1("busy_wrack", wrAck, 1'b0);
    tick();
    chk1("busy_no_late_wrack", wrAck, 1'b0);
    chk1("busy_no_err", err, 1'b0);
    do_read(32'h00F, 1'b1, "busy_reread");

    // Reset while in RD aborts the read but keeps the array.
    req = 1'b1; CS = 1'b1; iWE = 1'b0; iAddress = 32'h3FF;
    tick();
    req = 1'b0;
    chk1("rstrd_in_rd", ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("rstrd_ready", ready, 1'b1);
    chk1("rstrd_dvalid", dataValid, 1'b0);
    chk("rstrd_dout", dataOut, 32'h0);
    chk1("rstrd_wrack", wrAck, 1'b0);
    chk1("rstrd_err", err, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk1("rstrd_no_dvalid", dataValid, 1'b0);
    end
    rst_n = 1'b1;
    do_read(32'h3FF, 1'b1, "rstrd_reread");
    do_read(32'h00F, 1'b1, "rstrd_reread2");

    // Randomized mix checked against the model.
    for (int n = 0; n < 150; n++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 4 || wr_q.size() == 0) begin
        do_write({22'h0, 10'($urandom_range(0, 1023))}, $urandom, 1'b1, "rnd_wr");
      end else if (op <= 7) begin
        k = wr_q[$urandom_range(0, wr_q.size() - 1)];
        do_read(32'(k), 1'b1, "rnd_rd");
      end else begin
        if (op == 8) begin
          a = {22'h0, 10'($urandom_range(0, 1023))};
          CS = 1'b0;
        end else begin
          a = {22'($urandom_range(1, 32'h3FFFFF)), 10'($urandom_range(0, 1023))};
        end
        d = $urandom;
        if ($urandom_range(0, 1) == 1) begin
          do_write(a, d, (op == 9), "rnd_rej_wr");
        end else begin
          do_read(a, (op == 9), "rnd_rej_rd");
        end
      end
    end

    // Final sweep of every written index.
    for (int i = 0; i < wr_q.size(); i += 7) begin
      do_read(32'(wr_q[i]), 1'b1, "sweep_rd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 Parameter DEPTH, default 1024: number of 32-bit words; matches the decoder window 0x192E..0x1D2D.
REQ-002 Parameter ADDR_W, default 10: index width; DEPTH SHALL equal 2^ADDR_W.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  access strobe; sampled only when ready=1.
REQ-006 CS  input  1  chip select from the address decoder.
REQ-007 iWE  input  1  gated write enable from the decoder; 1=write, 0=read.
REQ-008 iAddress  input  32  decoder-relative word index.
REQ-009 dataIn  input  32  write data.
REQ-010 ready  output  1  1 = controller accepts a req this cycle.
REQ-011 dataOut  output  32  read data; valid only while dataValid=1.
REQ-012 dataValid  output  1  one-cycle pulse marking completion of a read.
REQ-013 wrAck  output  1  one-cycle pulse marking completion of a write.
REQ-014 err  output  1  one-cycle pulse; the access was rejected.

Function
REQ-015 An access SHALL be accepted on a rising edge where req=1 and ready=1.
REQ-016 An accepted access SHALL be valid only if CS=1 and iAddress[31:ADDR_W]=0; otherwise it is rejected.
REQ-017 FSM states: IDLE, RD, RESP. Reset state is IDLE. ready=1 only in IDLE.
REQ-018 IDLE with a valid write accepted: mem[iAddress[ADDR_W-1:0]] <= dataIn on that edge; wrAck=1 for the next cycle; the FSM SHALL stay in IDLE.
REQ-019 IDLE with a valid read accepted: go to RD and latch the index. In RD the array is read into a registered output, then go to RESP.
REQ-020 In RESP, dataValid=1 and dataOut=word read; the next state is IDLE. Read latency is 2 cycles, measured from the accept edge to dataValid high.
REQ-021 A rejected access SHALL leave the array unchanged and set err=1 for the next cycle only. dataOut SHALL be 32'h0. The FSM stays in IDLE, and neither wrAck nor dataValid asserts.
REQ-022 A req while ready=0 SHALL be ignored. It is not queued, and no pulse is produced for it.
REQ-023 Back-to-back writes SHALL be accepted one per cycle, with one wrAck per write.
REQ-024 A read immediately after a write to the same index SHALL return the newly written data.
REQ-025 dataOut SHALL hold 32'h0 whenever dataValid=0.
REQ-026 At most one of dataValid, wrAck and err SHALL be high in any cycle.

Reset
REQ-027 rst_n=0 SHALL immediately force: FSM=IDLE, ready=1, dataValid=0, wrAck=0, err=0, dataOut=32'h0.
REQ-028 Reset SHALL NOT clear the memory array; contents are undefined after power-up.
REQ-029 Reset asserted during RD or RESP SHALL abort the read. No dataValid is produced for that read.
REQ-030 The first access SHALL be accepted on the first rising edge after rst_n returns high.

Configuration
REQ-031 Macro DMEM_BYTE_WRITE_EN defined: the block adds input byteEn[3:0]. A write updates only the bytes whose enable bit is 1; bit0 maps to dataIn[7:0]. A write with byteEn=4'b0000 SHALL still pulse wrAck.
REQ-032 Macro DMEM_BYTE_WRITE_EN undefined: the byteEn port SHALL NOT exist, and every write updates all 32 bits.

Verification
REQ-033 Write then read: write 0xDEADBEEF to index 0x00F, then read index 0x00F. Required: wrAck pulse 1 cycle after the write accept; dataValid with dataOut=0xDEADBEEF 2 cycles after the read accept.
REQ-034 Boundaries: write and read back index 0x000 (0x11111111) and index 0x3FF (0x22222222). Both SHALL read back correctly, with no aliasing between them.
REQ-035 Rejections: req with CS=0, then req with CS=1 and iAddress=0x400. Each SHALL give one err pulse, the array SHALL be unchanged, and the FSM SHALL stay in IDLE.
REQ-036 Busy and reset: issue a read, and drive req with a write to the same index in RD. The write SHALL be ignored and the original data returned. Then issue a second read and pull rst_n low in RD. Outputs SHALL go to reset values with no dataValid, and a read after reset SHALL still return the pre-reset stored data.
REQ-037 With DMEM_BYTE_WRITE_EN: write 0xAABBCCDD with byteEn=4'b1111, then 0x11223344 with byteEn=4'b0101. A read SHALL return 0xAA22CC44.
